// File: rtl/div.sv
// div: sequential 8-bit unsigned restoring divider that borrows a shared 16-bit adder
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   a_i, b_i, start    dividend, divisor and request (honoured only when idle)
//   busy, done         operation in flight, one-cycle result-valid pulse
//   div_by_zero        last accepted request had a zero divisor
//   quotient, remainder working registers, valid from done until the next start
//   sum_in_a, sum_in_b, sum_out  shared adder operands and its combinational result
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic [15:0] sum_in_a,
    output logic [15:0] sum_in_b,
    input  logic [15:0] sum_out
);
    typedef enum logic [1:0] {IDLE, NEG, SUB, INC} state_t;
    state_t state, next;
    logic [7:0]  a, b;
    logic [2:0]  ctr;
    logic [15:0] negb, partial;
    assign busy = state != IDLE;
    // ~ctr selects bit 7-ctr, walking the dividend from its MSB down
    assign partial = {7'b0, remainder, a[~ctr]};
    always_comb begin
        next     = state;
        sum_in_a = '0;
        sum_in_b = '0;
        case (state)
            IDLE: next = (start && b_i != 8'd0) ? NEG : IDLE;
            NEG: begin
                sum_in_a = {8'hFF, ~b};
                sum_in_b = 16'd1;
                next     = SUB;
            end
            SUB: begin
                sum_in_a = partial;
                sum_in_b = negb;
                next     = (ctr == 3'd7) ? IDLE : INC;
            end
            INC: begin
                sum_in_a = {13'b0, ctr};
                sum_in_b = 16'd1;
                next     = SUB;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a           <= '0;
            b           <= '0;
            ctr         <= '0;
            negb        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (b_i != 8'd0) begin
                        a           <= a_i;
                        b           <= b_i;
                        quotient    <= '0;
                        remainder   <= '0;
                        ctr         <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        quotient    <= 8'hFF;
                        remainder   <= a_i;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
                end
                NEG: negb <= sum_out;
                // sign of partial - b decides restore versus keep
                SUB: begin
                    remainder      <= sum_out[15] ? partial[7:0] : sum_out[7:0];
                    quotient[~ctr] <= ~sum_out[15];
                    if (ctr == 3'd7) done <= 1'b1;
                end
                INC: ctr <= sum_out[2:0];
            endcase
        end
endmodule

// File: tb/tb_div.sv
module tb_div;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a_i = '0, b_i = '0;
    logic        start = 1'b0;
    logic        busy, done, div_by_zero;
    logic [7:0]  quotient, remainder;
    logic [15:0] sum_in_a, sum_in_b, sum_out;
    int checks = 0;
    int errors = 0;

    div dut (
        .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .start(start),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder),
        .sum_in_a(sum_in_a), .sum_in_b(sum_in_b), .sum_out(sum_out)
    );

    assign sum_out = sum_in_a + sum_in_b;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_div(input logic [7:0] av, input logic [7:0] bv);
        int q, r;
        if (bv == 8'd0) return {8'hFF, av};
        q = int'(av) / int'(bv);
        r = int'(av) % int'(bv);
        return {q[7:0], r[7:0]};
    endfunction

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output int bcnt, output int dcnt, output int dat);
        bcnt = 0; dcnt = 0; dat = 0;
        @(negedge clk);
        a_i = av; b_i = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dat == 0) dat = k;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, quotient, remainder, sum_in_a, sum_in_b} !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d busy=%b done=%b q=%0d r=%0d sa=%h sb=%h expected all 0",
                         k, busy, done, quotient, remainder, sum_in_a, sum_in_b);
            end
        end
    endtask

    task automatic test_op(input logic [7:0] av, input logic [7:0] bv, input string nm);
        int bcnt, dcnt, dat;
        logic [15:0] e;
        e = ref_div(av, bv);
        do_op(av, bv, bcnt, dcnt, dat);
        checks++;
        if (quotient !== e[15:8] || remainder !== e[7:0]) begin
            errors++;
            $display("FAIL %s_result %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d",
                     nm, av, bv, quotient, remainder, e[15:8], e[7:0]);
        end
        checks++;
        if (div_by_zero !== (bv == 8'd0)) begin
            errors++;
            $display("FAIL %s_dbz %0d/%0d got %b expected %b", nm, av, bv, div_by_zero, bv == 8'd0);
        end
        checks++;
        if (bcnt != ((bv == 8'd0) ? 0 : 16) || dcnt != 1 || dat != ((bv == 8'd0) ? 1 : 17)) begin
            errors++;
            $display("FAIL %s_timing %0d/%0d got busy=%0d dones=%0d done_at=%0d expected busy=%0d dones=1 done_at=%0d",
                     nm, av, bv, bcnt, dcnt, dat, (bv == 8'd0) ? 0 : 16, (bv == 8'd0) ? 1 : 17);
        end
    endtask

    task automatic test_basic;
        test_op(8'd200, 8'd7, "basic");
        checks++;
        if (quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL basic_const got q=%0d r=%0d expected q=28 r=4", quotient, remainder);
        end
    endtask

    task automatic test_boundary;
        logic [7:0] av[4] = '{8'd255, 8'd5, 8'd255, 8'd128};
        logic [7:0] bv[4] = '{8'd1, 8'd9, 8'd255, 8'd16};
        for (int i = 0; i < 4; i++) test_op(av[i], bv[i], "boundary");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            test_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
    endtask

    task automatic test_div_zero;
        test_op(8'd77, 8'd0, "divzero");
        test_op(8'd10, 8'd3, "after_divzero");
    endtask

    task automatic test_ignore;
        int bcnt = 0, dcnt = 0;
        @(negedge clk);
        a_i = 8'd100; b_i = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bcnt++;
            if (done) dcnt++;
            if (k == 5) begin a_i = 8'd9; b_i = 8'd9; start = 1'b1; end
            if (k == 6) start = 1'b0;
        end
        checks++;
        if (quotient !== 8'd33 || remainder !== 8'd1 || bcnt != 16 || dcnt != 1) begin
            errors++;
            $display("FAIL ignore_start got q=%0d r=%0d busy=%0d dones=%0d expected q=33 r=1 busy=16 dones=1",
                     quotient, remainder, bcnt, dcnt);
        end
    endtask

    task automatic test_reset_mid;
        int dcnt = 0;
        @(negedge clk);
        a_i = 8'd250; b_i = 8'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 9; k++) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_before got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder, sum_in_a, sum_in_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b dbz=%b q=%0d r=%0d sa=%h sb=%h expected all 0",
                     busy, done, div_by_zero, quotient, remainder, sum_in_a, sum_in_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d busy/done cycles expected 0", dcnt);
        end
        test_op(8'd250, 8'd6, "after_reset");
    endtask

    task automatic test_back_to_back;
        int dat = 0;
        @(negedge clk);
        a_i = 8'd100; b_i = 8'd7; start = 1'b1;
        for (int k = 1; k <= 17; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL b2b_first got done=%b busy=%b q=%0d r=%0d expected done=1 busy=0 q=14 r=2",
                     done, busy, quotient, remainder);
        end
        a_i = 8'd45; b_i = 8'd4;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept got busy=%b expected 1", busy);
        end
        for (int k = 2; k <= 19; k++) begin
            @(negedge clk);
            if (done && dat == 0) dat = k;
        end
        checks++;
        if (dat != 17 || quotient !== 8'd11 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL b2b_second got done_at=%0d q=%0d r=%0d expected done_at=17 q=11 r=1",
                     dat, quotient, remainder);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundary;
        test_div_zero;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
